// File: rtl/nibble_sweep_bist.sv
// nibble_sweep_bist: sweeps every WIDTH-bit code into a combinational checker,
// holds each code for HOLD cycles, samples the checker response on the last
// hold cycle, and reports a per-code signature plus a count of set responses.
module nibble_sweep_bist #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned HOLD  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      y_in,
  output logic [WIDTH-1:0]          a_out,
  output logic                      busy,
  output logic                      done,
  output logic [(1 << WIDTH)-1:0]   signature,
  output logic [WIDTH:0]            ones_count
);

  localparam int unsigned NCODES = 1 << WIDTH;
  localparam int unsigned CW     = WIDTH + 1;
  localparam int unsigned HW     = 8;

  localparam logic [WIDTH-1:0] LAST_CODE = {WIDTH{1'b1}};
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_q,      state_d;
  logic [WIDTH-1:0]    code_q,       code_d;
  logic [HW-1:0]       hold_cnt_q,   hold_cnt_d;
  logic [NCODES-1:0]   signature_q,  signature_d;
  logic [CW-1:0]       ones_count_q, ones_count_d;
  logic                busy_q,       busy_d;
  logic                done_q,       done_d;

  // Next-state logic: sweep sequencing, sampling and flag generation.
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    hold_cnt_d   = hold_cnt_q;
    signature_d  = signature_q;
    ones_count_d = ones_count_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_DRIVE;
          code_d       = '0;
          hold_cnt_d   = '0;
          signature_d  = '0;
          ones_count_d = '0;
        end
      end

      ST_DRIVE: begin
        if (hold_cnt_q == HOLD_LAST) begin
          signature_d[code_q] = y_in;
          ones_count_d        = ones_count_q + CW'(y_in);
          hold_cnt_d          = '0;
          // Terminal code is detected before incrementing, so code never wraps.
          if (code_q == LAST_CODE) begin
            state_d = ST_DONE;
          end else begin
            code_d = code_q + WIDTH'(1);
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flags are registered copies of the upcoming state, so they align with it.
    busy_d = (state_d == ST_DRIVE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      code_q       <= '0;
      hold_cnt_q   <= '0;
      signature_q  <= '0;
      ones_count_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      hold_cnt_q   <= hold_cnt_d;
      signature_q  <= signature_d;
      ones_count_q <= ones_count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign a_out      = code_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign signature  = signature_q;
  assign ones_count = ones_count_q;

endmodule
